// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the processor-side memory bus initiator.
// Provides the bus command and access-size encodings, address width,
// memory tag width and the tag-table entry layout.
package mem_bus_master_pkg;

    localparam int XLEN        = 32;
    localparam int MEM_LATENCY = 10;
    localparam int MEM_TAG_W   = 4;

    // Width of the client id stored per tag; covers up to 4 clients.
    localparam int CLIENT_ID_W = 2;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef struct packed {
        logic                   valid;
        logic [CLIENT_ID_W-1:0] client;
    } MEM_TAG_ENTRY;

endpackage

// File: rtl/mem_bus_master_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clock, reset   - clock and asynchronous active-low reset
//   request [N]    - request lines
//   advance        - the current grant was consumed; move the pointer past it
//   grant [N]      - one-hot grant, combinational
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] request,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] next_ptr;
    logic [PW-1:0] idx;
    logic          found;

    // Scan from the pointer upward (wrapping); first requester wins.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        idx      = '0;
        found    = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && request[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                next_ptr    = PW'((int'(ptr) + k + 1) % N);
            end
        end
    end

    // Pointer only moves when the winner is actually taken, so a
    // rejected client keeps its priority.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/mem_bus_master.sv
// Processor-side initiator for the unified memory bus.
// Arbitrates client load/store requests onto one proc2mem port, records the
// tag memory assigns to each accepted load, and routes tagged returns back
// to the issuing client.
// Ports:
//   clock, reset                 - clock, asynchronous active-low reset
//   req_valid/command/addr/data/size [NUM_CLIENTS] - client requests
//   req_ready [NUM_CLIENTS]      - request accepted this cycle (combinational)
//   resp_valid [NUM_CLIENTS], resp_data - registered load return
//   proc2mem_command/addr/data/size - bus request (combinational)
//   mem2proc_response            - tag for this cycle's request, 0 = rejected
//   mem2proc_data, mem2proc_tag  - load return, tag 0 = nothing
//   bad_tag                      - registered pulse on return of an unknown tag
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int NUM_CLIENTS     = 3,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_CLIENTS-1:0]             req_valid,
    input  logic [NUM_CLIENTS-1:0][1:0]        req_command,
    input  logic [NUM_CLIENTS-1:0][XLEN-1:0]   req_addr,
    input  logic [NUM_CLIENTS-1:0][63:0]       req_data,
    input  logic [NUM_CLIENTS-1:0][1:0]        req_size,
    output logic [NUM_CLIENTS-1:0]             req_ready,
    output logic [NUM_CLIENTS-1:0]             resp_valid,
    output logic [63:0]                        resp_data,
    output logic [1:0]                         proc2mem_command,
    output logic [XLEN-1:0]                    proc2mem_addr,
    output logic [63:0]                        proc2mem_data,
    output logic [1:0]                         proc2mem_size,
    input  logic [MEM_TAG_W-1:0]               mem2proc_response,
    input  logic [63:0]                        mem2proc_data,
    input  logic [MEM_TAG_W-1:0]               mem2proc_tag,
    output logic                               bad_tag
);

    localparam int         TAG_ENTRIES = 2 ** MEM_TAG_W;
    localparam logic [3:0] MAX_CNT     = 4'(MAX_OUTSTANDING);

    MEM_TAG_ENTRY [TAG_ENTRIES-1:0] tag_table;
    logic [3:0]                     count;

    logic [NUM_CLIENTS-1:0]  eligible;
    logic [NUM_CLIENTS-1:0]  grant;
    logic [CLIENT_ID_W-1:0]  win_id;
    logic                    win_load;
    logic                    accept;
    logic                    alloc;
    logic                    at_limit;
    MEM_TAG_ENTRY            ret_entry;
    logic                    ret_hit;
    logic [NUM_CLIENTS-1:0]  ret_onehot;

    assign at_limit = (count >= MAX_CNT);

    // Loads are held back at the in-flight limit; stores never are.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            eligible[i] = req_valid[i] &&
                          ((req_command[i] == BUS_STORE) ||
                           ((req_command[i] == BUS_LOAD) && !at_limit));
        end
    end

    rr_arbiter #(.N(NUM_CLIENTS)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .request (eligible),
        .advance (accept),
        .grant   (grant)
    );

    // Winner mux onto the bus; idle bus is BUS_NONE with zeroed fields.
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        proc2mem_size    = '0;
        win_id           = '0;
        win_load         = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant[i]) begin
                proc2mem_command = req_command[i];
                proc2mem_addr    = req_addr[i];
                proc2mem_data    = req_data[i];
                proc2mem_size    = req_size[i];
                win_id           = CLIENT_ID_W'(i);
                win_load         = (req_command[i] == BUS_LOAD);
            end
        end
    end

    assign accept    = (|grant) && (mem2proc_response != '0);
    assign alloc     = accept && win_load;
    assign req_ready = accept ? grant : '0;

    assign ret_entry = tag_table[mem2proc_tag];
    assign ret_hit   = (mem2proc_tag != '0) && ret_entry.valid;

    always_comb begin
        ret_onehot = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            ret_onehot[i] = ret_hit && (ret_entry.client == CLIENT_ID_W'(i));
        end
    end

    // The allocation write comes after the retire clear, so when one tag
    // is retired and reassigned in the same cycle the new owner survives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_table  <= '0;
            count      <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            bad_tag    <= 1'b0;
        end else begin
            if (ret_hit) begin
                tag_table[mem2proc_tag].valid <= 1'b0;
            end
            if (alloc) begin
                tag_table[mem2proc_response] <= '{valid: 1'b1, client: win_id};
            end
            count      <= count + {3'b0, alloc} - {3'b0, ret_hit};
            resp_valid <= ret_onehot;
            if (ret_hit) begin
                resp_data <= mem2proc_data;
            end
            bad_tag    <= (mem2proc_tag != '0) && !ret_entry.valid;
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: directed scenarios followed by a
// randomized phase, all compared against a tag-map reference model.
module tb_mem_bus_master;
    import mem_bus_master_pkg::*;

    localparam int N    = 3;
    localparam int MAXO = 2;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic [N-1:0]            req_valid;
    logic [N-1:0][1:0]       req_command;
    logic [N-1:0][XLEN-1:0]  req_addr;
    logic [N-1:0][63:0]      req_data;
    logic [N-1:0][1:0]       req_size;
    logic [N-1:0]            req_ready;
    logic [N-1:0]            resp_valid;
    logic [63:0]             resp_data;
    logic [1:0]              proc2mem_command;
    logic [XLEN-1:0]         proc2mem_addr;
    logic [63:0]             proc2mem_data;
    logic [1:0]              proc2mem_size;
    logic [3:0]              mem2proc_response;
    logic [63:0]             mem2proc_data;
    logic [3:0]              mem2proc_tag;
    logic                    bad_tag;

    mem_bus_master #(.NUM_CLIENTS(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_command       (req_command),
        .req_addr          (req_addr),
        .req_data          (req_data),
        .req_size          (req_size),
        .req_ready         (req_ready),
        .resp_valid        (resp_valid),
        .resp_data         (resp_data),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .proc2mem_size     (proc2mem_size),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag),
        .bad_tag           (bad_tag)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: priority pointer and tag -> owning client (-1 = free).
    int ptr;
    int tbl[16];

    logic [N-1:0]    seen_ready;
    logic [1:0]      seen_cmd;
    logic [XLEN-1:0] seen_addr;

    int q[$];
    int ret_t, pick, roll;
    logic [N-1:0] exp_grant;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        ptr = 0;
        for (int t = 0; t < 16; t++) tbl[t] = -1;
    endfunction

    function automatic int n_out();
        int n = 0;
        for (int t = 1; t < 16; t++) if (tbl[t] >= 0) n++;
        return n;
    endfunction

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (req_valid[c] && (req_command[c] == BUS_STORE ||
                (req_command[c] == BUS_LOAD && n_out() < MAXO)))
                return c;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        req_valid = '0; req_command = '0; req_addr = '0; req_data = '0; req_size = '0;
        mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    endtask

    task automatic set_req(input int c, input logic [1:0] cmd, input logic [XLEN-1:0] a,
                           input logic [63:0] d, input logic [1:0] sz);
        req_valid[c] = 1'b1; req_command[c] = cmd; req_addr[c] = a;
        req_data[c] = d; req_size[c] = sz;
    endtask

    // One clock cycle: check bus outputs against the model mid-cycle, advance
    // the model, then check registered outputs just after the edge.
    task automatic tick();
        int w;
        logic [N-1:0] erv;
        logic [63:0]  edata;
        logic         ebad;
        #1;
        w = winner();
        seen_ready = req_ready; seen_cmd = proc2mem_command; seen_addr = proc2mem_addr;
        if (w < 0) begin
            check("bus_cmd_idle", proc2mem_command, BUS_NONE);
            check("bus_addr_idle", proc2mem_addr, 0);
            check("bus_data_idle", proc2mem_data, 0);
        end else begin
            check("bus_cmd", proc2mem_command, req_command[w]);
            check("bus_addr", proc2mem_addr, req_addr[w]);
            check("bus_data", proc2mem_data, req_data[w]);
            check("bus_size", proc2mem_size, req_size[w]);
        end
        check("req_ready", req_ready, (w >= 0 && mem2proc_response != 0) ? (1 << w) : 0);
        erv = '0; edata = '0; ebad = 1'b0;
        if (mem2proc_tag != 0) begin
            if (tbl[mem2proc_tag] >= 0) begin
                erv[tbl[mem2proc_tag]] = 1'b1;
                edata = mem2proc_data;
                tbl[mem2proc_tag] = -1;
            end else begin
                ebad = 1'b1;
            end
        end
        if (w >= 0 && mem2proc_response != 0) begin
            ptr = (w + 1) % N;
            if (req_command[w] == BUS_LOAD) tbl[mem2proc_response] = w;
        end
        @(posedge clock);
        #1;
        check("resp_valid", resp_valid, erv);
        if (erv != 0) check("resp_data", resp_data, edata);
        check("bad_tag", bad_tag, ebad);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_cmd", proc2mem_command, BUS_NONE);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_bad_tag", bad_tag, 0);
        check("rst_ready", req_ready, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single load, returned after the memory latency.
        set_req(0, BUS_LOAD, 'h40, 0, WORD);
        mem2proc_response = 4'd3;
        tick();
        check("single_ready", seen_ready, 3'b001);
        check("single_addr", seen_addr, 'h40);
        idle_inputs();
        repeat (MEM_LATENCY - 1) tick();
        mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD;
        tick();
        check("single_resp_valid", resp_valid, 3'b001);
        check("single_resp_data", resp_data, 64'hDEAD);
        idle_inputs();
        tick();
        check("single_resp_drop", resp_valid, 3'b000);

        // Round-robin among three stores.
        do_reset();
        for (int c = 0; c < N; c++) set_req(c, BUS_STORE, XLEN'('h100 + c * 8), 64'(c + 100), DOUBLE);
        for (int i = 0; i < 4; i++) begin
            mem2proc_response = 4'(i + 1);
            exp_grant = 3'(1 << (i % 3));
            tick();
            check("rr_grant", seen_ready, exp_grant);
        end

        // Rejection: client 1 keeps the grant until accepted.
        idle_inputs();
        set_req(1, BUS_LOAD, 'h200, 0, HALF);
        for (int i = 0; i < 4; i++) begin
            mem2proc_response = 4'd0;
            tick();
            check("rej_ready", seen_ready, 3'b000);
            check("rej_cmd", seen_cmd, BUS_LOAD);
        end
        mem2proc_response = 4'd5;
        tick();
        check("rej_accept", seen_ready, 3'b010);
        idle_inputs();
        mem2proc_tag = 4'd5; mem2proc_data = 64'h5555;
        tick();
        check("rej_entry_client", resp_valid, 3'b010);
        idle_inputs();
        tick();

        // Outstanding limit: third load withheld, store still goes.
        do_reset();
        set_req(0, BUS_LOAD, 'h300, 0, WORD);
        mem2proc_response = 4'd1; tick(); check("lim_l1", seen_ready, 3'b001);
        mem2proc_response = 4'd2; tick(); check("lim_l2", seen_ready, 3'b001);
        set_req(2, BUS_STORE, 'h400, 64'h77, WORD);
        mem2proc_response = 4'd7; tick();
        check("lim_store", seen_ready, 3'b100);
        check("lim_store_cmd", seen_cmd, BUS_STORE);
        req_valid[2] = 1'b0;
        mem2proc_response = 4'd9; tick();
        check("lim_withheld", seen_ready, 3'b000);
        check("lim_withheld_cmd", seen_cmd, BUS_NONE);
        mem2proc_tag = 4'd1; mem2proc_data = 64'h1111;
        tick();
        check("lim_still_full", seen_ready, 3'b000);
        mem2proc_tag = 4'd0; mem2proc_response = 4'd1;
        tick();
        check("lim_l3", seen_ready, 3'b001);
        idle_inputs(); mem2proc_tag = 4'd2; tick();
        idle_inputs(); mem2proc_tag = 4'd1; tick();
        idle_inputs(); tick();

        // Same tag retired and reallocated in one cycle.
        do_reset();
        set_req(0, BUS_LOAD, 'h500, 0, WORD);
        mem2proc_response = 4'd4; tick();
        check("reuse_first", seen_ready, 3'b001);
        idle_inputs();
        set_req(2, BUS_LOAD, 'h600, 0, BYTE);
        mem2proc_response = 4'd4; mem2proc_tag = 4'd4; mem2proc_data = 64'hBEEF;
        tick();
        check("reuse_alloc", seen_ready, 3'b100);
        check("reuse_ret_valid", resp_valid, 3'b001);
        check("reuse_ret_data", resp_data, 64'hBEEF);
        idle_inputs();
        set_req(0, BUS_LOAD, 'h540, 0, WORD);
        mem2proc_response = 4'd6; tick();
        check("reuse_cnt_one", seen_ready, 3'b001);
        mem2proc_response = 4'd8; tick();
        check("reuse_cnt_two", seen_ready, 3'b000);
        idle_inputs(); mem2proc_tag = 4'd4; mem2proc_data = 64'hCAFE;
        tick();
        check("reuse_new_owner", resp_valid, 3'b100);
        idle_inputs(); mem2proc_tag = 4'd6; tick();
        idle_inputs(); tick();

        // Reset with loads in flight: their returns become bad tags.
        do_reset();
        set_req(0, BUS_LOAD, 'h700, 0, WORD);
        mem2proc_response = 4'd1; tick();
        idle_inputs();
        set_req(1, BUS_LOAD, 'h708, 0, WORD);
        mem2proc_response = 4'd2; tick();
        do_reset();
        mem2proc_tag = 4'd1; mem2proc_data = 64'h1;
        tick();
        check("rmf_bad1", bad_tag, 1'b1);
        check("rmf_noresp1", resp_valid, 3'b000);
        mem2proc_tag = 4'd2; tick();
        check("rmf_bad2", bad_tag, 1'b1);
        idle_inputs(); tick();
        check("rmf_bad_clear", bad_tag, 1'b0);

        // Randomized traffic; memory never reissues a tag still in flight.
        do_reset();
        repeat (400) begin
            for (int c = 0; c < N; c++) begin
                req_valid[c]   = 1'($urandom_range(0, 1));
                req_command[c] = 2'($urandom_range(0, 2));
                req_addr[c]    = $urandom;
                req_data[c]    = {$urandom, $urandom};
                req_size[c]    = 2'($urandom_range(0, 3));
            end
            roll = $urandom_range(0, 9);
            ret_t = 0;
            q.delete();
            for (int t = 1; t < 16; t++) if (tbl[t] >= 0) q.push_back(t);
            if (roll < 5 && q.size() > 0) ret_t = q[$urandom_range(0, q.size() - 1)];
            else if (roll == 5) ret_t = $urandom_range(1, 15);
            mem2proc_tag  = 4'(ret_t);
            mem2proc_data = {$urandom, $urandom};
            q.delete();
            for (int t = 1; t < 16; t++) if (tbl[t] < 0 || t == ret_t) q.push_back(t);
            pick = ($urandom_range(0, 3) == 0 || q.size() == 0) ? 0 : q[$urandom_range(0, q.size() - 1)];
            mem2proc_response = 4'(pick);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
